// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: bundles the start/status, RAM/ROM read, butterfly and RAM write signals of ntt_ctrl.
// Latency: none; the interface holds wires only.
// Backpressure: none; the sequencer runs a fixed schedule and never stalls.
interface ntt_ctrl_if #(
  parameter int LOG_N = 8,
  parameter int W     = 23
);
  logic             start_i;
  logic             mode_i;
  logic             busy_o;
  logic             done_o;
  logic             rd_en_o;
  logic [LOG_N-1:0] rd_addr_a_o;
  logic [LOG_N-1:0] rd_addr_b_o;
  logic [W-1:0]     rd_data_a_i;
  logic [W-1:0]     rd_data_b_i;
  logic [LOG_N-1:0] tw_addr_o;
  logic [W-1:0]     tw_data_i;
  logic [W:0]       bf_a_o;
  logic [W:0]       bf_b_o;
  logic [W:0]       bf_twiddle_o;
  logic             bf_sel_butterfly_o;
  logic [W-1:0]     bf_a_prime_i;
  logic [W-1:0]     bf_b_prime_i;
  logic             wr_en_o;
  logic [LOG_N-1:0] wr_addr_a_o;
  logic [LOG_N-1:0] wr_addr_b_o;
  logic [W-1:0]     wr_data_a_o;
  logic [W-1:0]     wr_data_b_o;

  // Sequencer side.
  modport master (
    input  start_i, mode_i,
    input  rd_data_a_i, rd_data_b_i, tw_data_i,
    input  bf_a_prime_i, bf_b_prime_i,
    output busy_o, done_o,
    output rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
    output bf_a_o, bf_b_o, bf_twiddle_o, bf_sel_butterfly_o,
    output wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_data_a_o, wr_data_b_o
  );

  // RAM / ROM / butterfly side.
  modport slave (
    output start_i, mode_i,
    output rd_data_a_i, rd_data_b_i, tw_data_i,
    output bf_a_prime_i, bf_b_prime_i,
    input  busy_o, done_o,
    input  rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
    input  bf_a_o, bf_b_o, bf_twiddle_o, bf_sel_butterfly_o,
    input  wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_data_a_o, wr_data_b_o
  );
endinterface

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: in-place NTT (CT) / INTT (GS) sequencer, one butterfly per cycle over a dual-port RAM.
// Latency: issue -> butterfly operands +1 cycle -> writeback +2 cycles; LOG_N*(N/2+2)+1 cycles start to done.
// Backpressure: none; start_i is only honoured in IDLE, a 2-cycle drain separates stages.
module ntt_ctrl #(
  parameter int LOG_N = 8,
  parameter int W     = 23
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ntt_ctrl_if.master bus
);

  localparam int               HALF   = 1 << (LOG_N - 1);
  localparam logic [LOG_N-1:0] LAST_I = LOG_N'(HALF - 1);
  localparam logic [LOG_N-1:0] LAST_S = LOG_N'(LOG_N - 1);
  localparam logic [LOG_N-1:0] ONES   = {LOG_N{1'b1}};
  localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_mode;
  logic [LOG_N-1:0] r_s;
  logic [LOG_N-1:0] r_i;
  logic             r_drain;

  logic             w_busy;
  logic             w_done;
  logic             w_rd_en;

  logic [LOG_N-1:0] w_shift;
  logic [LOG_N-1:0] w_len;
  logic [LOG_N-1:0] w_grp;
  logic [LOG_N-1:0] w_a;
  logic [LOG_N-1:0] w_b;
  logic [LOG_N-1:0] w_tw;

  logic             r_ret_vld;
  logic [LOG_N-1:0] r_ret_a;
  logic [LOG_N-1:0] r_ret_b;
  logic             r_wr_en;
  logic [LOG_N-1:0] r_wr_a;
  logic [LOG_N-1:0] r_wr_b;
  logic [W-1:0]     r_wr_dat_a;
  logic [W-1:0]     r_wr_dat_b;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state strobes; the drain waits out the last write of the stage.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy  = 1'b1;
        w_rd_en = 1'b1;
        if (r_i == LAST_I) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (r_drain) begin
          w_state_nxt = (r_s == LAST_S) ? S_DONE : S_RUN;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stage / butterfly counters and the mode latched on start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode  <= 1'b0;
      r_s     <= '0;
      r_i     <= '0;
      r_drain <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_mode  <= bus.mode_i;
            r_s     <= '0;
            r_i     <= '0;
            r_drain <= 1'b0;
          end
        end
        S_RUN: begin
          r_i     <= (r_i == LAST_I) ? '0 : r_i + ONE;
          r_drain <= 1'b0;
        end
        S_DRAIN: begin
          r_drain <= ~r_drain;
          if (r_drain) begin
            r_s <= r_s + ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pair and twiddle address: a is i with a zero inserted at bit log2(len), b = a | len.
  // Forward halves len each stage, inverse doubles it; (N>>s)-1 is simply ONES>>s.
  always_comb begin
    w_shift = r_mode ? r_s : (LAST_S - r_s);
    w_len   = ONE << w_shift;
    w_grp   = r_i >> w_shift;
    w_a     = ((w_grp << w_shift) << 1) | (r_i & (w_len - ONE));
    w_b     = w_a | w_len;
    w_tw    = r_mode ? ((ONES >> r_s) - w_grp) : ((ONE << r_s) + w_grp);
  end

  // Return and writeback pipeline; reset drops any in-flight write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ret_vld  <= 1'b0;
      r_ret_a    <= '0;
      r_ret_b    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_a     <= '0;
      r_wr_b     <= '0;
      r_wr_dat_a <= '0;
      r_wr_dat_b <= '0;
    end else begin
      r_ret_vld <= w_rd_en;
      if (w_rd_en) begin
        r_ret_a <= w_a;
        r_ret_b <= w_b;
      end
      r_wr_en <= r_ret_vld;
      if (r_ret_vld) begin
        r_wr_a     <= r_ret_a;
        r_wr_b     <= r_ret_b;
        r_wr_dat_a <= bus.bf_a_prime_i;
        r_wr_dat_b <= bus.bf_b_prime_i;
      end
    end
  end

  assign bus.busy_o             = w_busy;
  assign bus.done_o             = w_done;
  assign bus.rd_en_o            = w_rd_en;
  assign bus.rd_addr_a_o        = w_rd_en ? w_a  : '0;
  assign bus.rd_addr_b_o        = w_rd_en ? w_b  : '0;
  assign bus.tw_addr_o          = w_rd_en ? w_tw : '0;
  assign bus.bf_a_o             = {1'b0, bus.rd_data_a_i};
  assign bus.bf_b_o             = {1'b0, bus.rd_data_b_i};
  assign bus.bf_twiddle_o       = {1'b0, bus.tw_data_i};
  assign bus.bf_sel_butterfly_o = r_mode;
  assign bus.wr_en_o            = r_wr_en;
  assign bus.wr_addr_a_o        = r_wr_a;
  assign bus.wr_addr_b_o        = r_wr_b;
  assign bus.wr_data_a_o        = r_wr_dat_a;
  assign bus.wr_data_b_o        = r_wr_dat_b;

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: checks ntt_ctrl schedule, data path and start/reset edge cases.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_ntt_ctrl;

  localparam longint Q    = 64'd8380417;
  localparam longint PSI  = 64'd1753;
  localparam longint NINV = 64'd8347681;
  localparam int     N8   = 256;
  localparam int     TLEN = 8 * (N8 / 2 + 2) + 2;
  localparam int     BIG  = 32'h7fffffff;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;
  bit   chk_en;

  ntt_ctrl_if #(.LOG_N(8), .W(23)) bus8 ();
  ntt_ctrl_if #(.LOG_N(3), .W(23)) bus3 ();

  ntt_ctrl #(.LOG_N(8), .W(23)) dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8));
  ntt_ctrl #(.LOG_N(3), .W(23)) dut3 (.clk_i(clk), .rst_i(rst), .bus(bus3));

  // Model: expected issue schedule per relative cycle, per mode.
  int ev  [2][TLEN];
  int ea  [2][TLEN];
  int eb  [2][TLEN];
  int etw [2][TLEN];
  int m_t0;
  int m_mode;
  int m_end;

  int tab3 [2][12];

  logic [22:0] ram   [N8];
  longint      zetas [N8];
  longint      xin   [N8];
  longint      fres  [N8];
  bit          ld_en;
  int          ld_addr;
  longint      ld_dat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int brv8(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r |= 1 << (7 - i);
    return r;
  endfunction

  function automatic longint modpow(input longint b, input int e);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  // Textbook loop nests: CT walks zetas upward from 1, GS walks them downward from N.
  task automatic build_model();
    int t;
    int k;
    t = 1; k = 0;
    for (int len = N8 / 2; len >= 1; len = len / 2) begin
      for (int st = 0; st < N8; st += 2 * len) begin
        k++;
        for (int j = st; j < st + len; j++) begin
          ev[0][t] = 1; ea[0][t] = j; eb[0][t] = j + len; etw[0][t] = k; t++;
        end
      end
      t += 2;
    end
    t = 1; k = N8;
    for (int len = 1; len < N8; len = len * 2) begin
      for (int st = 0; st < N8; st += 2 * len) begin
        k--;
        for (int j = st; j < st + len; j++) begin
          ev[1][t] = 1; ea[1][t] = j; eb[1][t] = j + len; etw[1][t] = k; t++;
        end
      end
      t += 2;
    end
  endtask

  // RAM and twiddle ROM for the N=256 instance: one-cycle read latency.
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_dat[22:0];
    if (bus8.wr_en_o) begin
      ram[bus8.wr_addr_a_o] <= bus8.wr_data_a_o;
      ram[bus8.wr_addr_b_o] <= bus8.wr_data_b_o;
    end
    if (bus8.rd_en_o) begin
      bus8.rd_data_a_i <= ram[bus8.rd_addr_a_o];
      bus8.rd_data_b_i <= ram[bus8.rd_addr_b_o];
      bus8.tw_data_i   <= zetas[bus8.tw_addr_o][22:0];
    end
  end

  // Reference butterfly: CT a+zb / a-zb, GS a+b / z(b-a).
  always_comb begin
    longint a, b, z, t, pa, pb;
    a  = longint'(bus8.bf_a_o);
    b  = longint'(bus8.bf_b_o);
    z  = longint'(bus8.bf_twiddle_o);
    t  = 0;
    pa = 0;
    pb = 0;
    if (!bus8.bf_sel_butterfly_o) begin
      t  = (z * (b % Q)) % Q;
      pa = (a + t) % Q;
      pb = ((a % Q) - t + Q) % Q;
    end else begin
      pa = (a + b) % Q;
      pb = (z * (((b % Q) - (a % Q) + Q) % Q)) % Q;
    end
    bus8.bf_a_prime_i = pa[22:0];
    bus8.bf_b_prime_i = pb[22:0];
  end

  // Cycle-by-cycle comparison of the N=256 instance against the model schedule.
  always @(negedge clk) begin
    int rel;
    bit act;
    int e_rd, e_wr;
    if (chk_en) begin
      rel  = cyc - m_t0;
      act  = (cyc < m_end) && (rel >= 0) && (rel < TLEN);
      e_rd = 0;
      e_wr = 0;
      if (act) e_rd = ev[m_mode][rel];
      if (act && rel >= 2) e_wr = ev[m_mode][rel - 2];
      chk("busy", bus8.busy_o, (act && rel >= 1 && rel <= TLEN - 2) ? 1 : 0);
      chk("done", bus8.done_o, (act && rel == TLEN - 1) ? 1 : 0);
      chk("rd_en", bus8.rd_en_o, e_rd);
      chk("wr_en", bus8.wr_en_o, e_wr);
      if (e_rd != 0) begin
        chk("rd_addr_a", bus8.rd_addr_a_o, ea[m_mode][rel]);
        chk("rd_addr_b", bus8.rd_addr_b_o, eb[m_mode][rel]);
        chk("tw_addr", bus8.tw_addr_o, etw[m_mode][rel]);
      end
      if (e_wr != 0) begin
        chk("wr_addr_a", bus8.wr_addr_a_o, ea[m_mode][rel - 2]);
        chk("wr_addr_b", bus8.wr_addr_b_o, eb[m_mode][rel - 2]);
      end
      if (act && rel >= 1) chk("bf_sel", bus8.bf_sel_butterfly_o, m_mode);
    end
  end

  // N=8 instance: captured issue order against the hand table.
  task automatic run3(input int md);
    int n;
    int drel;
    n    = 0;
    drel = -1;
    bus3.mode_i  = md[0];
    bus3.start_i = 1'b1;
    step;
    bus3.start_i = 1'b0;
    bus3.mode_i  = ~md[0];
    for (int r = 1; r <= 30; r++) begin
      if (bus3.rd_en_o) begin
        if (n < 12) begin
          chk("order3", int'(bus3.rd_addr_a_o) * 256 + int'(bus3.rd_addr_b_o) * 16 + int'(bus3.tw_addr_o),
              tab3[md][n]);
        end
        if (md == 1) chk("sel3", bus3.bf_sel_butterfly_o, 1);
        n++;
      end
      if (bus3.done_o && drel < 0) drel = r;
      step;
    end
    chk("count3", n, 12);
    chk("done3_cycle", drel, 19);
  endtask

  // N=256 run: start pulse at rel 500 and mode toggling must both be ignored.
  task automatic run8(input int md, output int drel);
    int c0;
    bus8.mode_i  = md[0];
    bus8.start_i = 1'b1;
    c0     = cyc;
    m_t0   = c0;
    m_mode = md;
    m_end  = BIG;
    step;
    bus8.start_i = 1'b0;
    drel = -1;
    for (int r = 1; r <= 1200; r++) begin
      if (bus8.done_o) begin
        drel = r;
        break;
      end
      bus8.start_i = (r == 500);
      bus8.mode_i  = md[0] ^ ((r >= 200) && (r < 700));
      step;
    end
    bus8.start_i = 1'b0;
  endtask

  initial begin
    int     drel;
    longint w, p, acc;
    cyc = 0; n_chk = 0; n_err = 0; chk_en = 0;
    m_t0 = 0; m_mode = 0; m_end = 0;
    ld_en = 0; ld_addr = 0; ld_dat = 0;
    rst = 1'b1;
    bus8.start_i = 1'b0; bus8.mode_i = 1'b0;
    bus8.rd_data_a_i = '0; bus8.rd_data_b_i = '0; bus8.tw_data_i = '0;
    bus3.start_i = 1'b0; bus3.mode_i = 1'b0;
    bus3.rd_data_a_i = '0; bus3.rd_data_b_i = '0; bus3.tw_data_i = '0;
    bus3.bf_a_prime_i = '0; bus3.bf_b_prime_i = '0;
    tab3 = '{'{'h041, 'h151, 'h261, 'h371, 'h022, 'h132, 'h463, 'h573, 'h014, 'h235, 'h456, 'h677},
             '{'h017, 'h236, 'h455, 'h674, 'h023, 'h133, 'h462, 'h572, 'h041, 'h151, 'h261, 'h371}};
    build_model();
    for (int k = 0; k < N8; k++) zetas[k] = modpow(PSI, brv8(k));
    for (int j = 0; j < N8; j++) xin[j] = (longint'(j) * j * 4099 + 17 * j + 3) % Q;

    step; step; step;
    chk("rst_busy", bus8.busy_o, 0);
    chk("rst_done", bus8.done_o, 0);
    chk("rst_rd_en", bus8.rd_en_o, 0);
    chk("rst_wr_en", bus8.wr_en_o, 0);
    chk("rst_wr_addr_a", bus8.wr_addr_a_o, 0);
    chk("rst_wr_data_b", bus8.wr_data_b_o, 0);
    chk("rst_bf_sel", bus8.bf_sel_butterfly_o, 0);
    chk("rst_rd_addr_b", bus8.rd_addr_b_o, 0);
    rst = 1'b0;
    step;
    chk_en = 1;

    chk("model_f1_a", ea[0][1], 0);
    chk("model_f1_b", eb[0][1], 128);
    chk("model_f1_tw", etw[0][1], 1);
    chk("model_drain", ev[0][129] + ev[0][130], 0);
    chk("model_f131_b", eb[0][131], 64);
    chk("model_f131_tw", etw[0][131], 2);
    chk("model_flast_tw", etw[0][1038], 255);
    chk("model_flast_a", ea[0][1038], 254);
    chk("model_i1_tw", etw[1][1], 255);
    chk("model_i2_a", ea[1][2], 2);
    chk("model_i2_tw", etw[1][2], 254);

    run3(0);
    run3(1);

    for (int j = 0; j < N8; j++) begin
      ld_en = 1; ld_addr = j; ld_dat = xin[j];
      step;
    end
    ld_en = 0;
    step;

    run8(0, drel);
    chk("fwd_done_cycle", drel, TLEN - 1);
    bus8.start_i = 1'b1;
    bus8.mode_i  = 1'b1;
    step;
    for (int j = 0; j < N8; j++) fres[j] = longint'(ram[j]);
    run8(1, drel);
    chk("inv_done_cycle", drel, TLEN - 1);

    for (int i = 0; i < N8; i++) begin
      w = modpow(PSI, 2 * brv8(i) + 1);
      p = 1;
      acc = 0;
      for (int j = 0; j < N8; j++) begin
        acc = (acc + xin[j] * p) % Q;
        p = (p * w) % Q;
      end
      chk("fwd_vs_sw_ntt", fres[i], acc);
    end
    step; step;
    for (int j = 0; j < N8; j++) chk("roundtrip", (longint'(ram[j]) * NINV) % Q, xin[j]);

    bus8.mode_i  = 1'b0;
    bus8.start_i = 1'b1;
    m_t0 = cyc; m_mode = 0; m_end = BIG;
    step;
    bus8.start_i = 1'b0;
    repeat (299) step;
    rst   = 1'b1;
    m_end = cyc + 1;
    step;
    rst = 1'b0;
    chk("rst_mid_rd_en", bus8.rd_en_o, 0);
    chk("rst_mid_wr_en", bus8.wr_en_o, 0);
    chk("rst_mid_busy", bus8.busy_o, 0);
    step;
    run8(0, drel);
    chk("post_rst_done_cycle", drel, TLEN - 1);
    step; step;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for an in-place N-point NTT (Cooley-Tukey, forward) or INTT (Gentleman-Sande, inverse). It feeds the combinational butterfly unit and consumes its results. Each cycle it reads an operand pair from a dual-port coefficient RAM and a twiddle from a twiddle ROM. It presents these to the butterfly, then writes the butterfly results back to the same addresses. Final N^-1 scaling of the INTT is out of scope.

## Interface
Parameters:
- LOG_N, default 8: log2 of transform size; N = 2^LOG_N (256 coefficients).
- W, default 23: coefficient/twiddle width (q < 2^23).

Ports (clock and reset first):
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  0 = forward CT, 1 = inverse GS; latched when start is accepted.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse after the final write.
- rd_en_o  out  1  RAM read strobe.
- rd_addr_a_o, rd_addr_b_o  out  LOG_N  read addresses.
- rd_data_a_i, rd_data_b_i  in  W  RAM data, valid the cycle after rd_en_o.
- tw_addr_o  out  LOG_N  twiddle ROM address, issued with the read addresses.
- tw_data_i  in  W  twiddle, valid the cycle after.
- bf_a_o, bf_b_o, bf_twiddle_o  out  W+1  butterfly operands: {1'b0, data}.
- bf_sel_butterfly_o  out  1  latched mode.
- bf_a_prime_i, bf_b_prime_i  in  W  butterfly results (combinational).
- wr_en_o  out  1  RAM write strobe.
- wr_addr_a_o, wr_addr_b_o  out  LOG_N  write addresses.
- wr_data_a_o, wr_data_b_o  out  W  write data.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start_i=1 latches mode_i, clears s=0 and i=0, and moves to RUN.
  - RUN: issues one butterfly per cycle, i = 0..N/2-1. After issuing i=N/2-1 it moves to DRAIN.
  - DRAIN: lasts exactly 2 cycles. It then goes to RUN with s+1 and i=0, or to DONE if s=LOG_N-1.
  - DONE: lasts 1 cycle, then goes to IDLE.
- The drain is mandatory. The next stage must not read an address before the previous stage's write to it completes. No read-during-write on the same address ever occurs.
- Stage length: forward uses len = N/2 >> s; inverse uses len = 1 << s. Let L = log2(len).
- Address generation:
  - Group g = i >> L.
  - a = i with a 0 inserted at bit position L.
  - b = a | len.
- Twiddle address: forward is (1 << s) + g; inverse is (N >> s) - 1 - g.
- Pipeline:
  - Issue cycle: rd_en_o=1 with addresses and tw_addr_o.
  - Next cycle: bf_* are driven from the returning data. bf_a_prime_i and bf_b_prime_i are registered into wr_data_*, and a and b are delayed into wr_addr_*.
  - Following cycle: wr_en_o=1.
- bf_* outputs are purely combinational from the rd/tw data inputs. Their value is don't-care when no data is returning.
- start_i is ignored outside IDLE, including DONE.
- mode_i changes after acceptance have no effect.

## Timing
- Reset values: state IDLE. busy_o, done_o, rd_en_o and wr_en_o are 0. All address and data registers and bf_sel_butterfly_o are 0.
- Reset mid-operation: from the next cycle, rd_en_o=0 and wr_en_o=0. In-flight writes are discarded and the FSM is in IDLE.
- Cycle 0 is the start_i cycle.
  - Stage s issues in cycles 1+s(N/2+2) through s(N/2+2)+N/2.
  - Each write occurs 2 cycles after its issue.
  - done_o fires in cycle 1+LOG_N(N/2+2): cycle 1041 for N=256.
  - busy_o is high in cycles 1 through LOG_N(N/2+2).
- Throughput: one butterfly per cycle in RUN. There are LOG_N·N/2 butterflies in total (1024 for N=256).
- A new start_i is accepted the cycle after done_o, so back-to-back transforms are possible.

## Test plan
- Forward, LOG_N=3: issue order is (a,b,tw) =
  - (0,4,1), (1,5,1), (2,6,1), (3,7,1);
  - (0,2,2), (1,3,2), (4,6,3), (5,7,3);
  - (0,1,4), (2,3,5), (4,5,6), (6,7,7).
  - done_o is in cycle 19.
- Inverse, LOG_N=3: issue order is
  - (0,1,7), (2,3,6), (4,5,5), (6,7,4);
  - (0,2,3), (1,3,3), (4,6,2), (5,7,2);
  - then all four len-4 pairs with tw 1.
  - bf_sel_butterfly_o=1 throughout.
- Data path: use a RAM model, a twiddle ROM, and a reference butterfly with q=8380417 and N=256. Forward then inverse followed by scaling by 256^-1 mod q must reproduce the input. Forward output must match a software NTT.
- Write timing: each wr_en_o appears exactly 2 cycles after the matching rd_en_o, with the same address pair. No rd_en_o occurs during the 2 DRAIN cycles of each stage.
- Start and mode edge cases:
  - A start_i pulse at cycle 500 during RUN is ignored.
  - Toggling mode_i mid-run has no effect.
  - start_i in the DONE cycle is ignored.
  - start_i in the cycle after done_o starts a new transform.
- Reset: asserting rst_i at cycle 300 for 1 cycle gives rd_en_o=0, wr_en_o=0 and busy_o=0 from cycle 301. A subsequent start completes normally in 1041 cycles.
